// File: rtl/atm_session_arbiter.sv
// Round-robin arbiter/sequencer sharing one ATM transaction core among N requesters.
// Optional per-account failure lockout enabled by defining ATM_ARB_LOCKOUT_EN.
module atm_session_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned TXN_CYCLES = 4,
  parameter int unsigned ACCOUNTS   = 10,
  localparam int unsigned IDW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [3*N-1:0]    req_op,
  input  logic [4*N-1:0]    req_acc,
  input  logic [16*N-1:0]   req_pin,
  input  logic [16*N-1:0]   req_newpin,
  input  logic [32*N-1:0]   req_amount,
  input  logic [N-1:0]      req_lang,
  output logic [N-1:0]      gnt,
  output logic              busy,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_balance,
  output logic              rsp_success,
  output logic              rsp_locked,
  output logic              core_rst_n,
  output logic [2:0]        core_op,
  output logic [3:0]        core_acc,
  output logic [15:0]       core_pin,
  output logic [15:0]       core_newpin,
  output logic [31:0]       core_amount,
  output logic              core_lang,
  input  logic [31:0]       core_balance,
  input  logic              core_success
);

  localparam int unsigned CW = $clog2(TXN_CYCLES + 1);

  if (N < 2 || N > 8 || ACCOUNTS > 15 || TXN_CYCLES < 1) begin : g_bad_cfg
    $error("atm_session_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d, cur_id_q, cur_id_d, winner_c, idx_c;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_d;
  logic            busy_d, rsp_valid_d, rsp_success_d, rsp_locked_d, core_rst_n_d, core_lang_d;
  logic [IDW-1:0]  rsp_id_d;
  logic [31:0]     rsp_balance_d, core_amount_d;
  logic [2:0]      core_op_d;
  logic [3:0]      core_acc_d;
  logic [15:0]     core_pin_d, core_newpin_d;

  // First requester after the last winner, wrapping; the lowest offset wins
  always_comb begin
    winner_c = last_q;
    idx_c    = '0;
    for (int i = N; i >= 1; i--) begin
      idx_c = IDW'((int'(last_q) + i) % N);
      if (req[idx_c]) winner_c = idx_c;
    end
  end

`ifdef ATM_ARB_LOCKOUT_EN
  logic [1:0] fail_cnt [1:ACCOUNTS];
  logic       locked_c;

  always_comb begin
    locked_c = 1'b0;
    for (int a = 1; a <= ACCOUNTS; a++)
      if (core_acc == 4'(a) && fail_cnt[a] == 2'd3) locked_c = 1'b1;
  end

  // Failure counters follow the outcome presented in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 1; a <= ACCOUNTS; a++) fail_cnt[a] <= 2'd0;
    end else if (state_q == DONE) begin
      for (int a = 1; a <= ACCOUNTS; a++) begin
        if (core_acc == 4'(a)) begin
          if (rsp_success)               fail_cnt[a] <= 2'd0;
          else if (fail_cnt[a] != 2'd3)  fail_cnt[a] <= fail_cnt[a] + 2'd1;
        end
      end
    end
  end
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cur_id_d      = cur_id_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id;
    rsp_balance_d = rsp_balance;
    rsp_success_d = rsp_success;
    rsp_locked_d  = rsp_locked;
    core_rst_n_d  = 1'b0;
    core_op_d     = core_op;
    core_acc_d    = core_acc;
    core_pin_d    = core_pin;
    core_newpin_d = core_newpin;
    core_amount_d = core_amount;
    core_lang_d   = core_lang;
    case (state_q)
      IDLE, DONE: begin
        if (|req) begin
          state_d         = LOAD;
          last_d          = winner_c;
          cur_id_d        = winner_c;
          gnt_d[winner_c] = 1'b1;
          core_op_d       = req_op[3*int'(winner_c) +: 3];
          core_acc_d      = req_acc[4*int'(winner_c) +: 4];
          core_pin_d      = req_pin[16*int'(winner_c) +: 16];
          core_newpin_d   = req_newpin[16*int'(winner_c) +: 16];
          core_amount_d   = req_amount[32*int'(winner_c) +: 32];
          core_lang_d     = req_lang[winner_c];
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef ATM_ARB_LOCKOUT_EN
        if (locked_c) begin
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = cur_id_q;
          rsp_balance_d = '0;
          rsp_success_d = 1'b0;
          rsp_locked_d  = 1'b1;
        end else
`endif
        begin
          state_d      = RUN;
          cnt_d        = '0;
          core_rst_n_d = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CW'(TXN_CYCLES - 1)) begin
          state_d       = DONE;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = cur_id_q;
          rsp_balance_d = core_balance;
          rsp_success_d = core_success;
          rsp_locked_d  = 1'b0;
        end else begin
          cnt_d        = cnt_q + CW'(1);
          core_rst_n_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(N - 1);
      cur_id_q    <= '0;
      cnt_q       <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_balance <= '0;
      rsp_success <= 1'b0;
      rsp_locked  <= 1'b0;
      core_rst_n  <= 1'b0;
      core_op     <= '0;
      core_acc    <= '0;
      core_pin    <= '0;
      core_newpin <= '0;
      core_amount <= '0;
      core_lang   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cur_id_q    <= cur_id_d;
      cnt_q       <= cnt_d;
      gnt         <= gnt_d;
      busy        <= busy_d;
      rsp_valid   <= rsp_valid_d;
      rsp_id      <= rsp_id_d;
      rsp_balance <= rsp_balance_d;
      rsp_success <= rsp_success_d;
      rsp_locked  <= rsp_locked_d;
      core_rst_n  <= core_rst_n_d;
      core_op     <= core_op_d;
      core_acc    <= core_acc_d;
      core_pin    <= core_pin_d;
      core_newpin <= core_newpin_d;
      core_amount <= core_amount_d;
      core_lang   <= core_lang_d;
    end
  end

endmodule

// File: tb/tb_atm_session_arbiter.sv
// Directed bench for atm_session_arbiter with a tiny behavioural ATM core.
module tb_atm_session_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned T = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [3*N-1:0]    req_op;
  logic [4*N-1:0]    req_acc;
  logic [16*N-1:0]   req_pin, req_newpin;
  logic [32*N-1:0]   req_amount;
  logic [N-1:0]      req_lang;
  logic [N-1:0]      gnt;
  logic              busy, rsp_valid, rsp_success, rsp_locked, core_rst_n, core_lang;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_balance, core_amount, core_balance;
  logic [2:0]        core_op;
  logic [3:0]        core_acc;
  logic [15:0]       core_pin, core_newpin;
  logic              core_success;
  logic [127:0]      all_outs;

  int checks = 0;
  int failures = 0;

  atm_session_arbiter #(.N(N), .TXN_CYCLES(T), .ACCOUNTS(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acc(req_acc),
    .req_pin(req_pin), .req_newpin(req_newpin), .req_amount(req_amount),
    .req_lang(req_lang), .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_balance(rsp_balance), .rsp_success(rsp_success),
    .rsp_locked(rsp_locked), .core_rst_n(core_rst_n), .core_op(core_op),
    .core_acc(core_acc), .core_pin(core_pin), .core_newpin(core_newpin),
    .core_amount(core_amount), .core_lang(core_lang),
    .core_balance(core_balance), .core_success(core_success)
  );

  always #5 clk = ~clk;

  assign all_outs = {13'd0, gnt, busy, rsp_valid, rsp_id, rsp_balance, rsp_success, rsp_locked,
                     core_rst_n, core_op, core_acc, core_pin, core_newpin, core_amount, core_lang};

  function automatic logic [15:0] pin_of(input logic [3:0] acc);
    return 16'(int'(acc) * 1111 + 123);
  endfunction

  // Core stand-in: every account holds 1000; success means the PIN matched
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_balance <= 32'd0;
      core_success <= 1'b0;
    end else begin
      core_success <= (core_pin == pin_of(core_acc));
      core_balance <= (core_pin == pin_of(core_acc)) ? 32'd1000 : 32'd0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] acc,
                         input logic [15:0] pin, input logic [31:0] amt);
    req_op[3*i +: 3]      = op;
    req_acc[4*i +: 4]     = acc;
    req_pin[16*i +: 16]   = pin;
    req_newpin[16*i +: 16] = pin + 16'd1;
    req_amount[32*i +: 32] = amt;
    req_lang[i]           = acc[0];
    req[i]                = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 30) begin
      step();
      c++;
    end
    if (busy) chk({tag, "_idle_timeout"}, 128'd0, 128'd1);
  endtask

  // Watches n grants; each requester drops req once granted
  task automatic expect_grants(input string tag, input int n, input int exp_ids[4]);
    int gid[4];
    int gcyc[4];
    int cnt;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      gid[k] = -1;
      gcyc[k] = 0;
    end
    for (int c = 0; c < 80 && cnt < n; c++) begin
      step();
      if (rsp_valid) chk({tag, "_rstn_done"}, 128'(core_rst_n), 128'd0);
      if (gnt != '0) begin
        chk({tag, "_rstn_load"}, 128'(core_rst_n), 128'd0);
        for (int j = 0; j < N; j++)
          if (gnt[j]) begin
            gid[cnt] = j;
            req[j]   = 1'b0;
          end
        gcyc[cnt] = c;
        cnt++;
      end
    end
    chk({tag, "_count"}, 128'(cnt), 128'(n));
    chk({tag, "_first_lat"}, 128'(gcyc[0]), 128'd0);
    for (int k = 0; k < n; k++) chk({tag, "_order"}, 128'(gid[k]), 128'(exp_ids[k]));
    for (int k = 1; k < n; k++) chk({tag, "_spacing"}, 128'(gcyc[k] - gcyc[k-1]), 128'(T + 2));
    wait_idle(tag);
  endtask

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [31:0] amt;
    logic [31:0] bal;
    logic        succ;
    logic        locked;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 3'd3, 4'd1,  16'd1234,  32'd0,   32'd1000, 1'b1, 1'b0, T + 1};
    vecs[1] = '{2, 3'd3, 4'd1,  16'd9999,  32'd0,   32'd0,    1'b0, 1'b0, T + 1};
    vecs[2] = '{1, 3'd4, 4'd2,  16'd2346,  32'd50,  32'd0,    1'b0, 1'b0, T + 1};
    vecs[3] = '{3, 3'd4, 4'd2,  16'd2346,  32'd60,  32'd0,    1'b0, 1'b0, T + 1};
    vecs[4] = '{2, 3'd4, 4'd2,  16'd2346,  32'd70,  32'd0,    1'b0, 1'b0, T + 1};
`ifdef ATM_ARB_LOCKOUT_EN
    vecs[5] = '{0, 3'd4, 4'd2,  16'd2345,  32'd80,  32'd0,    1'b0, 1'b1, 1};
`else
    vecs[5] = '{0, 3'd4, 4'd2,  16'd2345,  32'd80,  32'd1000, 1'b1, 1'b0, T + 1};
`endif
    vecs[6] = '{1, 3'd3, 4'd0,  16'd123,   32'd0,   32'd1000, 1'b1, 1'b0, T + 1};
    vecs[7] = '{3, 3'd3, 4'd12, 16'd13455, 32'd5,   32'd1000, 1'b1, 1'b0, T + 1};

    rst = 1'b1;
    req = '0; req_op = '0; req_acc = '0; req_pin = '0;
    req_newpin = '0; req_amount = '0; req_lang = '0;
    repeat (3) step();
    chk("reset_outs", all_outs, 128'd0);
    rst = 1'b0;

    // All four requesting: served 0,1,2,3
    for (int i = 0; i < N; i++) set_req(i, 3'd3, 4'd1, 16'd1234, 32'd0);
    expect_grants("rr", 4, '{0, 1, 2, 3});

    // Wrap-around from last winner 3
    set_req(1, 3'd3, 4'd1, 16'd1234, 32'd0);
    set_req(3, 3'd3, 4'd1, 16'd1234, 32'd0);
    expect_grants("wrap", 2, '{1, 3, 0, 0});

    // Reset in the second RUN cycle aborts silently and restores the pointer
    begin
      logic seen;
      set_req(0, 3'd3, 4'd1, 16'd1234, 32'd0);
      step();
      chk("abort_gnt", 128'(gnt), 128'd1);
      req[0] = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("abort_outs", all_outs, 128'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < T + 4; c++) begin
        step();
        seen = seen | rsp_valid;
      end
      chk("abort_no_rsp", 128'(seen), 128'd0);
      set_req(0, 3'd3, 4'd1, 16'd1234, 32'd0);
      set_req(2, 3'd3, 4'd1, 16'd1234, 32'd0);
      expect_grants("post_rst", 2, '{0, 2, 0, 0});
    end

    // Single-request transaction table, including the lockout sequence
    for (int v = 0; v < 8; v++) begin
      int   lat;
      logic got;
      logic seen_run;
      wait_idle("tbl");
      set_req(vecs[v].id, vecs[v].op, vecs[v].acc, vecs[v].pin, vecs[v].amt);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
        step();
        lat++;
        got = (gnt != '0);
      end
      if (!got) chk("tbl_gnt_timeout", 128'd0, 128'd1);
      chk("tbl_gnt_lat", 128'(lat), 128'd1);
      chk("tbl_gnt", 128'(gnt), 128'(4'b0001 << vecs[v].id));
      chk("tbl_busy", 128'(busy), 128'd1);
      chk("tbl_rstn_load", 128'(core_rst_n), 128'd0);
      chk("tbl_core_fields", {core_op, core_acc, core_pin, core_newpin, core_amount, core_lang},
          {vecs[v].op, vecs[v].acc, vecs[v].pin, vecs[v].pin + 16'd1, vecs[v].amt, vecs[v].acc[0]});
      req[vecs[v].id] = 1'b0;
      lat = 0;
      got = 1'b0;
      seen_run = 1'b0;
      while (!got && lat < 20) begin
        step();
        lat++;
        seen_run = seen_run | core_rst_n;
        got = rsp_valid;
      end
      if (!got) chk("tbl_rsp_timeout", 128'd0, 128'd1);
      chk("tbl_rsp_lat", 128'(lat), 128'(vecs[v].lat));
      chk("tbl_rsp_id", 128'(rsp_id), 128'(vecs[v].id));
      chk("tbl_balance", 128'(rsp_balance), 128'(vecs[v].bal));
      chk("tbl_success", 128'(rsp_success), 128'(vecs[v].succ));
      chk("tbl_locked", 128'(rsp_locked), 128'(vecs[v].locked));
      chk("tbl_core_ran", 128'(seen_run), 128'(!vecs[v].locked));
      chk("tbl_rstn_done", 128'(core_rst_n), 128'd0);
    end
    wait_idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_session_arbiter.md
# atm_session_arbiter

Round-robin arbiter and sequencer that shares one ATM transaction core among `N` terminal requesters. Each transaction runs in a fixed sequence: grant, core reset pulse, fixed-length run window, then a response capture. The block drives all core inputs and returns the core's balance/success to the granted requester. It sits between the terminal front-ends and the single ATM core instance.

## Interface
- `N`, 4: number of requesters (2..8).
- `TXN_CYCLES`, 4: cycles the core inputs are held stable, with the core out of reset, per transaction.
- `ACCOUNTS`, 10: valid account numbers are 1..`ACCOUNTS` (lockout feature only).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: per-requester request level.
- `req_op` in 3N: operation code, packed, requester i at [3i+:3].
- `req_acc` in 4N: account number, packed.
- `req_pin` in 16N: PIN, packed.
- `req_newpin` in 16N: new PIN, packed.
- `req_amount` in 32N: amount, packed.
- `req_lang` in N: language select.
- `gnt` out N: one-hot, one-cycle grant pulse.
- `busy` out 1: high in every state except IDLE.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_id` out clog2(N): index of the requester being answered.
- `rsp_balance` out 32: captured core balance.
- `rsp_success` out 1: captured core success.
- `rsp_locked` out 1: transaction refused by lockout.
- `core_rst_n` out 1: core reset, active-low.
- `core_op` out 3, `core_acc` out 4, `core_pin` out 16, `core_newpin` out 16, `core_amount` out 32, `core_lang` out 1: core inputs.
- `core_balance` in 32, `core_success` in 1: core results.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE: if any `req` bit is high, pick a winner and go to LOAD.
- Arbitration: round-robin from pointer `last`. The winner is the first set `req` bit after `last`, wrapping N-1 to 0. `last` is set to the winner.
- LOAD (1 cycle):
  - `gnt[winner]`=1.
  - Winner's fields are latched into the `core_*` registers.
  - `core_rst_n`=0, which forces the core idle.
  - Next state is RUN.
- RUN (`TXN_CYCLES` cycles):
  - `core_rst_n`=1; `core_*` held constant.
  - On the final RUN edge, `core_balance`/`core_success` are captured.
  - Next state is DONE.
- DONE (1 cycle):
  - `rsp_valid`=1, `rsp_id`=winner, captured values presented.
  - `core_rst_n`=0.
  - If any `req` is high in DONE, arbitrate and go directly to LOAD; otherwise go to IDLE.
- Requester handshake:
  - Hold fields stable while `req`=1 until `gnt` is seen.
  - Drop `req` the cycle after `gnt`. A `req` still high is treated as a new request.
- No backpressure on the response path. A requester that misses `rsp_valid` loses the response.
- Requests arriving during LOAD or RUN wait; they are sampled in DONE.

## Timing
- Reset values: all outputs 0 (`gnt`, `busy`, `rsp_*`, `core_*`, `core_rst_n`=0). `last`=N-1, so requester 0 wins first.
- With `req` sampled high in IDLE at edge k:
  - `gnt` is high in cycle k+1.
  - RUN spans k+2..k+1+`TXN_CYCLES`.
  - `rsp_valid` is high in cycle k+2+`TXN_CYCLES`. This is 6 cycles after the sampling edge at defaults.
- Back-to-back throughput: one grant every `TXN_CYCLES`+2 cycles (6 at defaults).
- `rst` in any state, including mid-RUN:
  - Next cycle is IDLE with all outputs at reset values.
  - No `rsp_valid` is issued for the aborted transaction.
  - `last` returns to N-1; lockout counters are cleared.
- `rst` wins over all other events in the same cycle.

## Configuration
- Macro: `ATM_ARB_LOCKOUT_EN`.
- Defined:
  - One saturating 2-bit failure counter per account 1..`ACCOUNTS`.
  - In DONE, for an in-range account: `rsp_success`=0 increments the counter (saturating at 3); `rsp_success`=1 clears it.
  - At LOAD, if the latched account's counter is 3, the core is not run. `core_rst_n` stays 0, RUN is skipped and LOAD goes to DONE. DONE outputs `rsp_locked`=1, `rsp_success`=0, `rsp_balance`=0.
  - Account 0 or >`ACCOUNTS` bypasses the counters and always runs.
  - Counters clear only on `rst`.
- Undefined: no counters, `rsp_locked` tied 0, every grant runs the full RUN window.

## Test plan
- Single request, N=4: `req[0]` with op 3, acc 1, pin 1234 -> `gnt`=0001 one cycle after sampling; `rsp_valid` 6 cycles after sampling with `rsp_id` 0, `rsp_balance` 1000, `rsp_success` 1.
- `req`=1111 held (each requester dropping after its own grant) -> grants 0,1,2,3 in order, 6 cycles apart. `core_rst_n` is low in each LOAD and DONE.
- Wrap-around: after a grant to 3, `req`=1010 -> requester 1 granted, then 3.
- `rst` asserted in the 2nd RUN cycle -> next cycle all outputs 0 and no `rsp_valid`. Afterwards `req`=0101 -> requester 0 granted first.
- Lockout (macro on): three op-4 requests on acc 2 with pin 2346 -> each `rsp_success` 0, `rsp_locked` 0. A fourth with pin 2345 -> `rsp_locked` 1, `rsp_valid` one cycle after `gnt`, and `core_rst_n` never rises.
- Lockout (macro off): same sequence -> the fourth transaction runs a full RUN window with `rsp_locked` 0.
